m_io_squeeze: RTL and testbench

- Parametrised pin-reduction harness for size and timing estimates of m_midgetv_core in small packages.
- Replaces the fixed fake-IO logic with two parts:
  - a serial loader that builds the core's DAT_I word from one pin;
  - a multi-channel MISR that compacts wide output buses (ADR_O, DAT_O, ...) into a signature, read out serially on one pin.
- Sits between package pins and the core. Its own LUT count is reported separately so it can be subtracted from place/route results.

---
 rtl/m_io_squeeze_pkg.sv | 27 ++
 rtl/m_misr.sv | 45 ++++
 rtl/m_io_squeeze.sv | 161 ++++++++++++++++
 tb/tb_m_io_squeeze.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/m_io_squeeze_pkg.sv
// Shared constants for the pin-reduction harness: default MISR polynomials,
// readout FSM encoding and the parameter sanity check.
package m_io_squeeze_pkg;

  localparam int unsigned RdStateW = 1;

  typedef enum logic [RdStateW-1:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } rd_state_e;

  // Default feedback polynomial (x^w term implicit) for common signature widths.
  function automatic logic [31:0] default_poly(input int unsigned w);
    case (w)
      8:       return 32'h0000_0007;
      16:      return 32'h0000_1021;
      32:      return 32'h04C1_1DB7;
      default: return 32'h0000_0003;
    endcase
  endfunction

  // Observed buses are folded in whole signature-width slices.
  function automatic bit width_ok(input int unsigned ow, input int unsigned sw);
    return (sw != 0) && ((ow % sw) == 0);
  endfunction

endpackage

// File: rtl/m_misr.sv
// Fold tree plus multiple-input signature register.
module m_misr
  import m_io_squeeze_pkg::*;
#(
  parameter int unsigned          SIGWIDTH = 16,
  parameter logic [SIGWIDTH-1:0]  POLY     = SIGWIDTH'(default_poly(SIGWIDTH)),
  parameter logic [SIGWIDTH-1:0]  SEED     = '0,
  parameter int unsigned          NIN      = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [NIN-1:0]      data_i,
  output logic [SIGWIDTH-1:0] sig_o
);

  localparam int unsigned NSlice = NIN / SIGWIDTH;

  logic [SIGWIDTH-1:0] fold;
  logic [SIGWIDTH-1:0] sig_d, sig_q;

  // XOR all LSB-aligned slices together, then step the LFSR when enabled.
  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < NSlice; i++) begin
      fold = fold ^ data_i[i*SIGWIDTH +: SIGWIDTH];
    end
    sig_d = sig_q;
    if (en_i) begin
      sig_d = {sig_q[SIGWIDTH-2:0], 1'b0} ^ (sig_q[SIGWIDTH-1] ? POLY : '0) ^ fold;
    end
  end

  // Signature register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/m_io_squeeze.sv
// Pin-reduction harness: serial word loader feeding the core's DAT_I and a
// MISR compacting the core's output buses, read out serially on one pin.
module m_io_squeeze
  import m_io_squeeze_pkg::*;
#(
  parameter int unsigned         DWIDTH         = 32,
  parameter int unsigned         NCHAN          = 2,
  parameter int unsigned         OWIDTH         = 32,
  parameter int unsigned         SIGWIDTH       = 16,
  parameter logic [SIGWIDTH-1:0] POLY           = SIGWIDTH'(default_poly(SIGWIDTH)),
  parameter logic [SIGWIDTH-1:0] SEED           = '0,
  parameter bit                  ZERO_WHEN_IDLE = 1'b1
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    sin,
  input  logic                    sload,
  input  logic                    par_gate,
  output logic [DWIDTH-1:0]       par_o,
  output logic                    word_rdy,
  input  logic [NCHAN*OWIDTH-1:0] obs_i,
  input  logic                    obs_en,
  input  logic                    sig_capture,
  output logic                    sig_busy,
  output logic                    sout
);

  localparam bit          ParamOk = width_ok(OWIDTH, SIGWIDTH);
  localparam int unsigned BcntW   = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam int unsigned RcntW   = $clog2(SIGWIDTH);

  if (!ParamOk) begin : g_bad_owidth
    $error("OWIDTH must be a multiple of SIGWIDTH");
  end

  // ---------------------------------------------------------------- loader
  logic [DWIDTH-1:0] sr_d, sr_q;
  logic [BcntW-1:0]  bcnt_d, bcnt_q;
  logic [DWIDTH-1:0] par_d, par_q;
  logic              word_rdy_d, word_rdy_q;
  logic [DWIDTH:0]   sr_ext;

  // Shift one bit per sload edge; the DWIDTH-th bit transfers the word.
  always_comb begin
    sr_ext     = {sr_q, sin};
    sr_d       = sr_q;
    bcnt_d     = bcnt_q;
    par_d      = par_q;
    word_rdy_d = 1'b0;
    if (sload) begin
      sr_d = sr_ext[DWIDTH-1:0];
      if (bcnt_q == BcntW'(DWIDTH - 1)) begin
        bcnt_d     = '0;
        par_d      = sr_ext[DWIDTH-1:0];
        word_rdy_d = 1'b1;
      end else begin
        bcnt_d = bcnt_q + BcntW'(1);
      end
    end
  end

  // Loader state.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      sr_q       <= '0;
      bcnt_q     <= '0;
      par_q      <= '0;
      word_rdy_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      bcnt_q     <= bcnt_d;
      par_q      <= par_d;
      word_rdy_q <= word_rdy_d;
    end
  end

  assign word_rdy = word_rdy_q;

  if (ZERO_WHEN_IDLE) begin : g_gate
    assign par_o = par_q & {DWIDTH{par_gate}};
  end else begin : g_nogate
    assign par_o = par_q;
  end

  // ------------------------------------------------------------------ MISR
  logic [SIGWIDTH-1:0] sig;

  m_misr #(
    .SIGWIDTH (SIGWIDTH),
    .POLY     (POLY),
    .SEED     (SEED),
    .NIN      (NCHAN * OWIDTH)
  ) u_misr (
    .clk_i  (CLK_I),
    .rst_i  (RST_I),
    .en_i   (obs_en),
    .data_i (obs_i),
    .sig_o  (sig)
  );

  // --------------------------------------------------------------- readout
  rd_state_e           st_d, st_q;
  logic [SIGWIDTH-1:0] shadow_d, shadow_q;
  logic [RcntW-1:0]    rcnt_d, rcnt_q;
  logic                busy_d, busy_q;
  logic                sout_d, sout_q;

  // Capture takes sig as registered (pre-update); sout is registered so it
  // always presents shadow's MSB during SHIFT and 0 in IDLE.
  always_comb begin
    st_d     = st_q;
    shadow_d = shadow_q;
    rcnt_d   = rcnt_q;
    busy_d   = busy_q;
    sout_d   = sout_q;
    unique case (st_q)
      StIdle: begin
        sout_d = 1'b0;
        if (sig_capture) begin
          st_d     = StShift;
          shadow_d = sig;
          rcnt_d   = '0;
          busy_d   = 1'b1;
          sout_d   = sig[SIGWIDTH-1];
        end
      end
      StShift: begin
        shadow_d = {shadow_q[SIGWIDTH-2:0], 1'b0};
        rcnt_d   = rcnt_q + RcntW'(1);
        sout_d   = shadow_q[SIGWIDTH-2];
        if (rcnt_q == RcntW'(SIGWIDTH - 1)) begin
          st_d   = StIdle;
          busy_d = 1'b0;
          sout_d = 1'b0;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  // Readout state and registered outputs.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      st_q     <= StIdle;
      shadow_q <= '0;
      rcnt_q   <= '0;
      busy_q   <= 1'b0;
      sout_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      shadow_q <= shadow_d;
      rcnt_q   <= rcnt_d;
      busy_q   <= busy_d;
      sout_q   <= sout_d;
    end
  end

  assign sig_busy = busy_q;
  assign sout     = sout_q;

endmodule

// File: tb/tb_m_io_squeeze.sv
// Scoreboard bench for m_io_squeeze: stimulus pushes expected words and
// signatures, a negedge monitor pops them when word_rdy / sig_busy appear.
module tb_m_io_squeeze;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        sin, sload, par_gate, obs_en, sig_capture;
  logic [63:0] obs_i;
  logic [31:0] par_o, par_o_nz;
  logic        word_rdy, sig_busy, sout;
  logic        word_rdy_nz, sig_busy_nz, sout_nz;

  int checks = 0;
  int errors = 0;
  int word_cnt = 0;

  logic [31:0] exp_word[$];
  logic [15:0] exp_sig[$];

  always #5 CLK_I = ~CLK_I;

  m_io_squeeze dut (
    .CLK_I       (CLK_I),
    .RST_I       (RST_I),
    .sin         (sin),
    .sload       (sload),
    .par_gate    (par_gate),
    .par_o       (par_o),
    .word_rdy    (word_rdy),
    .obs_i       (obs_i),
    .obs_en      (obs_en),
    .sig_capture (sig_capture),
    .sig_busy    (sig_busy),
    .sout        (sout)
  );

  m_io_squeeze #(
    .ZERO_WHEN_IDLE (1'b0)
  ) dut_nz (
    .CLK_I       (CLK_I),
    .RST_I       (RST_I),
    .sin         (sin),
    .sload       (sload),
    .par_gate    (par_gate),
    .par_o       (par_o_nz),
    .word_rdy    (word_rdy_nz),
    .obs_i       (obs_i),
    .obs_en      (obs_en),
    .sig_capture (sig_capture),
    .sig_busy    (sig_busy_nz),
    .sout        (sout_nz)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic [15:0] shbuf = '0;
  int          blen = 0;
  bit          collecting = 1'b0;

  always @(negedge CLK_I) begin
    if (RST_I) begin
      collecting = 1'b0;
      blen       = 0;
    end else begin
      if (word_rdy) begin
        word_cnt++;
        if (exp_word.size() == 0) begin
          chk("unexpected_word", par_o, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("word_par_o", par_o, exp_word.pop_front());
        end
      end
      if (sig_busy) begin
        if (!collecting) blen = 0;
        collecting = 1'b1;
        shbuf      = {shbuf[14:0], sout};
        blen++;
      end else if (collecting) begin
        collecting = 1'b0;
        chk("busy_len", blen, 16);
        chk("sout_idle", sout, 0);
        if (exp_sig.size() == 0) begin
          chk("unexpected_readout", shbuf, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("signature", shbuf, exp_sig.pop_front());
        end
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic do_reset();
    #2;
    RST_I = 1'b1;
    #1;
    chk("rst_par_o", par_o, 0);
    chk("rst_par_o_nz", par_o_nz, 0);
    chk("rst_word_rdy", word_rdy, 0);
    chk("rst_sig_busy", sig_busy, 0);
    chk("rst_sout", sout, 0);
    @(negedge CLK_I);
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
  endtask

  // Shift bits lo..hi-1 of w (MSB-first); a 3-cycle gap precedes bit gap_at.
  task automatic shift_range(input logic [31:0] w, input int lo, input int hi, input int gap_at);
    for (int i = lo; i < hi; i++) begin
      if (i == gap_at) begin
        sload = 1'b0;
        repeat (3) tick();
      end
      sin   = w[31-i];
      sload = 1'b1;
      tick();
    end
    sload = 1'b0;
    sin   = 1'b0;
  endtask

  task automatic obs_step(input logic [31:0] ch0, input logic [31:0] ch1, input int n);
    obs_i  = {ch1, ch0};
    obs_en = 1'b1;
    repeat (n) tick();
    obs_en = 1'b0;
    obs_i  = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sig_busy && n < 40) begin
      tick();
      n++;
    end
    chk("readout_done", sig_busy, 0);
    tick();
  endtask

  task automatic readout(input bit second);
    sig_capture = 1'b1;
    tick();
    sig_capture = 1'b0;
    if (second) begin
      repeat (4) tick();
      sig_capture = 1'b1;
      tick();
      sig_capture = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    sin = 0; sload = 0; par_gate = 0; obs_en = 0; sig_capture = 0; obs_i = '0;
    do_reset();

    // Loader with a gap mid-word.
    par_gate = 1'b1;
    exp_word.push_back(32'hDEAD_BEEF);
    shift_range(32'hDEAD_BEEF, 0, 32, 16);
    @(negedge CLK_I);
    chk("word_rdy_pulse", word_rdy, 1);
    tick();
    @(negedge CLK_I);
    chk("word_rdy_once", word_rdy, 0);
    chk("par_o_gate1", par_o, 32'hDEAD_BEEF);
    par_gate = 1'b0;
    #1;
    chk("par_o_gate0", par_o, 0);
    chk("par_o_nz_gate0", par_o_nz, 32'hDEAD_BEEF);
    par_gate = 1'b1;
    tick();

    // MISR stepping and simultaneous capture/update.
    do_reset();
    obs_step(32'h0001_0000, 32'h0, 1);
    exp_sig.push_back(16'h0001);
    readout(1'b0);
    obs_step(32'h0, 32'h0, 15);
    exp_sig.push_back(16'h8000);
    readout(1'b0);
    exp_sig.push_back(16'h8000);
    obs_i       = {32'h0, 32'h0001_0000};
    obs_en      = 1'b1;
    sig_capture = 1'b1;
    tick();
    obs_en      = 1'b0;
    sig_capture = 1'b0;
    obs_i       = '0;
    wait_idle();
    exp_sig.push_back(16'h1020);
    readout(1'b0);

    // Feedback step and ignored second capture.
    do_reset();
    obs_step(32'h0001_0000, 32'h0, 1);
    obs_step(32'h0, 32'h0, 16);
    exp_sig.push_back(16'h1021);
    readout(1'b1);

    // Fold cancellation across channels.
    do_reset();
    obs_step(32'h1234_5678, 32'h1234_5678, 10);
    exp_sig.push_back(16'h0000);
    readout(1'b0);

    // Async reset mid-load and mid-readout.
    exp_word.push_back(32'h0F0F_1234);
    shift_range(32'h0F0F_1234, 0, 32, -1);
    tick();
    chk("par_o_second", par_o, 32'h0F0F_1234);
    obs_step(32'h8001_0000, 32'h0, 1);
    shift_range(32'hCAFE_F00D, 0, 12, -1);
    sig_capture = 1'b1;
    tick();
    sig_capture = 1'b0;
    shift_range(32'hCAFE_F00D, 12, 20, -1);
    chk("busy_before_rst", sig_busy, 1);
    do_reset();
    exp_sig.push_back(16'h0000);
    readout(1'b0);
    exp_word.push_back(32'h1357_9BDF);
    shift_range(32'h1357_9BDF, 0, 32, -1);
    repeat (3) tick();

    for (int n = 0; n < 100 && (exp_word.size() != 0 || exp_sig.size() != 0); n++) tick();
    chk("pending_words", exp_word.size(), 0);
    chk("pending_sigs", exp_sig.size(), 0);
    chk("word_count", word_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
